// File: rtl/cbd_pkg.sv
// Shared types and sizing for the CBD sampling scheduler.
package cbd_pkg;

  localparam int CBD_MAX_POLYS      = 4;
  localparam int CBD_WORDS_PER_POLY = 64;
  localparam int CBD_WORD_W         = 48;
  localparam int CBD_ADDR_W         = 8;
  localparam int CBD_CNT_W          = 6;
  localparam int CBD_POLY_W         = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } cbd_state_e;

  // A job must contain at least one polynomial and no more than the buffer holds.
  function automatic logic k_legal(input logic [2:0] k, input int max_polys);
    return (k != 3'd0) && (int'(k) <= max_polys);
  endfunction

endpackage

// File: rtl/cbd_word_ctr.sv
// Per-polynomial sampler word counter with synchronous clear and terminal-count flag.
module cbd_word_ctr #(
  parameter int WIDTH    = 6,
  parameter int TERMINAL = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/cbd_sched.sv
// Sequences PRF requests and CBD sampler words for a multi-polynomial job into the write buffer.
module cbd_sched
  import cbd_pkg::*;
#(
  parameter int MAX_POLYS      = CBD_MAX_POLYS,
  parameter int WORDS_PER_POLY = CBD_WORDS_PER_POLY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  eta_sel,
  input  logic [2:0]            k_cfg,
  input  logic [7:0]            nonce_base,
  input  logic                  abort,
  output logic                  prf_req,
  output logic [7:0]            prf_nonce,
  input  logic                  prf_ack,
  output logic                  smp_reset,
  output logic                  smp_n,
  input  logic                  smp_done,
  input  logic [CBD_WORD_W-1:0] smp_out,
  output logic                  wb_we,
  output logic [CBD_ADDR_W-1:0] wb_addr,
  output logic [CBD_WORD_W-1:0] wb_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  cbd_state_e            state, next_state;
  logic                  eta_q;
  logic [2:0]            k_q;
  logic [CBD_POLY_W-1:0] poly_idx;
  logic [CBD_CNT_W-1:0]  word_cnt;
  logic                  word_tc;
  logic                  in_idle, start_ok, start_bad, word_wr, last_poly, kill;
  logic                  prf_req_d, smp_reset_d, busy_d, done_d;

  assign in_idle   = (state == ST_IDLE);
  assign start_ok  = in_idle && start && !abort && k_legal(k_cfg, MAX_POLYS);
  assign start_bad = in_idle && start && !abort && !k_legal(k_cfg, MAX_POLYS);
  assign kill      = abort && !in_idle;
  assign word_wr   = (state == ST_RUN) && smp_done && !abort;
  assign last_poly = ({1'b0, poly_idx} == (k_q - 3'd1));
  assign smp_n     = eta_q;

  cbd_word_ctr #(
    .WIDTH    (CBD_CNT_W),
    .TERMINAL (WORDS_PER_POLY - 1)
  ) u_word_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (word_wr),
    .clr   (start_ok || kill),
    .count (word_cnt),
    .tc    (word_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort overrides every transition out of a busy state, including a pending ack or last word.
  always_comb begin
    next_state = state;
    if (kill) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_ok) next_state = ST_REQ;
        ST_REQ:   if (prf_ack) next_state = ST_RUN;
        ST_RUN:   if (word_wr && word_tc) next_state = last_poly ? ST_DONE : ST_FLUSH;
        ST_FLUSH: next_state = ST_REQ;
        ST_DONE:  next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    prf_req_d   = (next_state == ST_REQ);
    smp_reset_d = (next_state != ST_RUN);
    busy_d      = (next_state == ST_REQ) || (next_state == ST_RUN) || (next_state == ST_FLUSH);
    done_d      = (next_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eta_q    <= 1'b0;
      k_q      <= 3'd0;
      poly_idx <= '0;
    end else if (start_ok) begin
      eta_q    <= eta_sel;
      k_q      <= k_cfg;
      poly_idx <= '0;
    end else if ((state == ST_FLUSH) && !abort) begin
      poly_idx <= poly_idx + 1'b1;
    end
  end

  // Nonce tracks nonce_base + poly_idx incrementally; 8-bit arithmetic gives the mod-256 wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prf_req   <= 1'b0;
      prf_nonce <= 8'd0;
      smp_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      prf_req   <= prf_req_d;
      smp_reset <= smp_reset_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= start_bad;
      wb_we     <= word_wr;
      if (start_ok) begin
        prf_nonce <= nonce_base;
      end else if ((state == ST_FLUSH) && !abort) begin
        prf_nonce <= prf_nonce + 8'd1;
      end
      if (word_wr) begin
        wb_addr <= {poly_idx, word_cnt};
        wb_data <= smp_out;
      end
    end
  end

endmodule

// File: tb/tb_cbd_sched.sv
// Self-checking bench for cbd_sched: vector table of jobs plus hand-built abort/reset/noise sequences.
module tb_cbd_sched;
  import cbd_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, eta_sel, abort, prf_ack, smp_done;
  logic [2:0]  k_cfg;
  logic [7:0]  nonce_base;
  logic [47:0] smp_out;
  logic        prf_req, smp_reset, smp_n, wb_we, busy, done, err;
  logic [7:0]  prf_nonce, wb_addr;
  logic [47:0] wb_data;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [55:0] exp_q[$];

  typedef struct {
    logic [2:0] k;
    logic       eta;
    logic [7:0] base;
    int         ack_dly;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  cbd_sched dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .eta_sel    (eta_sel),
    .k_cfg      (k_cfg),
    .nonce_base (nonce_base),
    .abort      (abort),
    .prf_req    (prf_req),
    .prf_nonce  (prf_nonce),
    .prf_ack    (prf_ack),
    .smp_reset  (smp_reset),
    .smp_n      (smp_n),
    .smp_done   (smp_done),
    .smp_out    (smp_out),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: event did not occur", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every observed write must match the oldest word driven while in RUN.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (wb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", wb_addr, wb_data);
      end else begin
        logic [55:0] e;
        e = exp_q.pop_front();
        check_output("wb_addr", wb_addr, e[55:48]);
        check_output("wb_data", wb_data, e[47:0]);
      end
    end
  end

  task automatic check_reset_outputs();
    check_output("rst_busy", busy, 0);
    check_output("rst_prf_req", prf_req, 0);
    check_output("rst_wb_we", wb_we, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    check_output("rst_smp_reset", smp_reset, 1);
    check_output("rst_prf_nonce", prf_nonce, 0);
    check_output("rst_wb_addr", wb_addr, 0);
    check_output("rst_wb_data", wb_data, 0);
  endtask

  task automatic bad_start(input logic [2:0] k);
    int e0;
    e0 = err_cnt;
    k_cfg = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("err_pulse", err, 1);
    check_output("err_busy", busy, 0);
    check_output("err_prf_req", prf_req, 0);
    tick();
    check_output("err_one_cycle", err, 0);
    check_output("err_busy_after", busy, 0);
    check_output("err_prf_req_after", prf_req, 0);
    check_output("err_count", err_cnt - e0, 1);
  endtask

  task automatic apply_stimulus(input logic [2:0] k, input logic eta, input logic [7:0] base,
                                input int ack_dly, input int abort_p, input int abort_w,
                                input int rst_p, input int rst_w, input bit noise);
    int d0;
    bit got;
    logic [63:0] r;
    d0 = done_cnt;
    eta_sel = eta;
    k_cfg = k;
    nonce_base = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < int'(k); p++) begin
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
        if (prf_req === 1'b1) got = 1'b1;
        else tick();
      end
      if (!got) begin
        fail_now("prf_req_timeout");
        return;
      end
      check_output("prf_nonce", prf_nonce, 8'(base + 8'(p)));
      check_output("smp_reset_req", smp_reset, 1);
      for (int c = 0; c < ack_dly; c++) begin
        if (noise) smp_done = 1'b1;
        tick();
      end
      smp_done = 1'b0;
      prf_ack = 1'b1;
      tick();
      prf_ack = 1'b0;
      check_output("prf_req_drop", prf_req, 0);
      check_output("smp_reset_run", smp_reset, 0);
      check_output("smp_n", smp_n, eta);
      check_output("busy_run", busy, 1);
      for (int w = 0; w < 64; w++) begin
        r = {$urandom(), $urandom()};
        if (p == abort_p && w == abort_w) begin
          smp_done = 1'b1;
          smp_out = r[47:0];
          abort = 1'b1;
          tick();
          abort = 1'b0;
          smp_done = 1'b0;
          check_output("abort_busy", busy, 0);
          check_output("abort_smp_reset", smp_reset, 1);
          check_output("abort_prf_req", prf_req, 0);
          return;
        end
        if (p == rst_p && w == rst_w) begin
          @(negedge clk);
          #1;
          reset = 1'b0;
          #1;
          check_reset_outputs();
          tick();
          tick();
          reset = 1'b1;
          tick();
          return;
        end
        smp_done = 1'b1;
        smp_out = r[47:0];
        exp_q.push_back({2'(p), 6'(w), r[47:0]});
        if (noise && w == 5) begin
          start = 1'b1;
          k_cfg = 3'd4;
          eta_sel = ~eta;
          nonce_base = 8'h99;
        end
        tick();
        start = 1'b0;
        eta_sel = eta;
      end
      smp_done = 1'b0;
      if (noise && p < int'(k) - 1) begin
        smp_done = 1'b1;
        tick();
        smp_done = 1'b0;
      end
    end
    check_output("done_pulse", done, 1);
    check_output("busy_at_done", busy, 0);
    tick();
    check_output("done_one_cycle", done, 0);
    check_output("busy_idle", busy, 0);
    check_output("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    vecs[0] = '{3'd2, 1'b0, 8'h10, 2, 1'b0};
    vecs[1] = '{3'd0, 1'b0, 8'h00, 0, 1'b1};
    vecs[2] = '{3'd5, 1'b0, 8'h00, 0, 1'b1};
    vecs[3] = '{3'd3, 1'b1, 8'hFF, 1, 1'b0};
    vecs[4] = '{3'd1, 1'b1, 8'h7F, 0, 1'b0};
    vecs[5] = '{3'd7, 1'b1, 8'h00, 0, 1'b1};

    reset = 1'b0;
    start = 1'b0;
    eta_sel = 1'b0;
    k_cfg = 3'd0;
    nonce_base = 8'd0;
    abort = 1'b0;
    prf_ack = 1'b0;
    smp_done = 1'b0;
    smp_out = '0;
    tick();
    tick();
    check_reset_outputs();
    reset = 1'b1;
    tick();
    check_output("idle_busy", busy, 0);
    check_output("idle_smp_reset", smp_reset, 1);

    foreach (vecs[i]) begin
      if (vecs[i].exp_err) bad_start(vecs[i].k);
      else apply_stimulus(vecs[i].k, vecs[i].eta, vecs[i].base, vecs[i].ack_dly, -1, -1, -1, -1, 1'b0);
      tick();
    end

    // Abort on word 30 of poly 1 while a sampler word is valid.
    d0 = done_cnt;
    apply_stimulus(3'd2, 1'b0, 8'h40, 1, 1, 30, -1, -1, 1'b0);
    tick();
    tick();
    check_output("abort_idle_busy", busy, 0);
    check_output("abort_no_done", done_cnt - d0, 0);
    check_output("abort_drained", exp_q.size(), 0);

    // Sampler strobes in REQ/FLUSH and a start pulse mid-RUN must be ignored.
    apply_stimulus(3'd2, 1'b1, 8'h20, 2, -1, -1, -1, -1, 1'b1);
    tick();

    // Reset mid-job at word 10 of poly 0, then a fresh single-poly job.
    apply_stimulus(3'd3, 1'b0, 8'h30, 1, -1, -1, 0, 10, 1'b0);
    check_output("post_reset_drained", exp_q.size(), 0);
    apply_stimulus(3'd1, 1'b0, 8'h00, 1, -1, -1, -1, -1, 1'b0);
    tick();

    // Abort together with start in IDLE drops the start.
    k_cfg = 3'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_output("idle_abort_busy", busy, 0);
    check_output("idle_abort_prf_req", prf_req, 0);
    check_output("idle_abort_err", err, 0);
    tick();
    check_output("idle_abort_busy2", busy, 0);
    check_output("idle_abort_prf_req2", prf_req, 0);

    check_output("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
